// File: rtl/qsys_timer_sequencer.sv
// Sequencer that drives an interval-timer slave over a simple word bus: programs the period,
// services timeouts, stops the timer and snapshots the live counter on request.
module qsys_timer_sequencer #(
    parameter int unsigned TICK_W     = 16,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_stop,
    input  logic              cmd_snap,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic [15:0]       tmr_readdata,
    input  logic              tmr_irq
);

    localparam logic [2:0]  AddrStatus  = 3'd0;
    localparam logic [2:0]  AddrControl = 3'd1;
    localparam logic [2:0]  AddrPerL    = 3'd2;
    localparam logic [2:0]  AddrPerH    = 3'd3;
    localparam logic [2:0]  AddrSnapL   = 3'd4;
    localparam logic [2:0]  AddrSnapH   = 3'd5;
    localparam logic [15:0] CtlStart    = 16'h0007;
    localparam logic [15:0] CtlStop     = 16'h0008;
    localparam logic [31:0] MinPeriod   = 32'(MIN_PERIOD);
    localparam logic [TICK_W-1:0] TickOne = {{(TICK_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        StIdle,
        StWrPl,
        StWrPh,
        StWrCtl,
        StRun,
        StClrSt,
        StWrStop,
        StClrStop,
        StSnapWr,
        StSnapRl,
        StSnapRh,
        StSnapCap
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [31:0]         r_load;
    logic [TICK_W-1:0]   r_tick_count;
    logic [15:0]         r_snap_lo;
    logic [31:0]         r_snap_value;
    logic                r_snap_ret;
    logic                r_running;

    logic                w_idle_run;
    logic                w_irq_take;
    logic                w_stop_acc;
    logic                w_start_acc;
    logic                w_snap_acc;
    logic [31:0]         w_period_clamped;

    // Commands are only sampled in IDLE/RUN; a pending irq in RUN masks all of them.
    assign w_idle_run  = (r_state == StIdle) || (r_state == StRun);
    assign w_irq_take  = (r_state == StRun) && tmr_irq;
    assign w_stop_acc  = w_idle_run && !w_irq_take && cmd_stop;
    assign w_start_acc = w_idle_run && !w_irq_take && !cmd_stop && cmd_start;
    assign w_snap_acc  = w_idle_run && !w_irq_take && !cmd_stop && !cmd_start && cmd_snap;

    assign w_period_clamped = (cmd_period < MinPeriod) ? MinPeriod : cmd_period;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle, StRun: begin
                if (w_irq_take) begin
                    w_state_d = StClrSt;
                end else if (w_stop_acc) begin
                    w_state_d = StWrStop;
                end else if (w_start_acc) begin
                    w_state_d = StWrPl;
                end else if (w_snap_acc) begin
                    w_state_d = StSnapWr;
                end
            end
            StWrPl:    w_state_d = StWrPh;
            StWrPh:    w_state_d = StWrCtl;
            StWrCtl:   w_state_d = StRun;
            StClrSt:   w_state_d = StRun;
            StWrStop:  w_state_d = StClrStop;
            StClrStop: w_state_d = StIdle;
            StSnapWr:  w_state_d = StSnapRl;
            StSnapRl:  w_state_d = StSnapRh;
            StSnapRh:  w_state_d = StSnapCap;
            StSnapCap: w_state_d = r_snap_ret ? StRun : StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load       <= '0;
            r_tick_count <= '0;
            r_snap_lo    <= '0;
            r_snap_value <= '0;
            r_snap_ret   <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_load       <= w_period_clamped - 32'd1;
                r_tick_count <= '0;
            end else if (r_state == StClrSt) begin
                r_tick_count <= r_tick_count + TickOne;
            end
            if (w_snap_acc) begin
                r_snap_ret <= (r_state == StRun);
            end
            // Read data is registered, so each half arrives one state after its address.
            if (r_state == StSnapRh) begin
                r_snap_lo <= tmr_readdata;
            end
            if (r_state == StSnapCap) begin
                r_snap_value <= {tmr_readdata, r_snap_lo};
            end
            if (r_state == StWrCtl) begin
                r_running <= 1'b1;
            end else if (w_stop_acc) begin
                r_running <= 1'b0;
            end
        end
    end

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        case (r_state)
            StWrPl: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrPerL;
                tmr_writedata  = r_load[15:0];
            end
            StWrPh: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrPerH;
                tmr_writedata  = r_load[31:16];
            end
            StWrCtl: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrControl;
                tmr_writedata  = CtlStart;
            end
            StClrSt, StClrStop: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrStatus;
            end
            StWrStop: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrControl;
                tmr_writedata  = CtlStop;
            end
            StSnapWr: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrSnapL;
            end
            StSnapRl: begin
                tmr_chipselect = 1'b1;
                tmr_address    = AddrSnapL;
            end
            StSnapRh: begin
                tmr_chipselect = 1'b1;
                tmr_address    = AddrSnapH;
            end
            default: begin
            end
        endcase
    end

    assign busy       = !w_idle_run;
    assign running    = r_running;
    assign tick       = (r_state == StClrSt);
    assign tick_count = r_tick_count;
    assign snap_valid = (r_state == StSnapCap);
    // Present the new value in the same cycle as the valid pulse.
    assign snap_value = snap_valid ? {tmr_readdata, r_snap_lo} : r_snap_value;

endmodule

// File: doc/qsys_timer_sequencer.md
QSYS_TIMER_SEQUENCER -- requirements
Module: qsys_timer_sequencer

Interface
REQ-001 SHALL have parameter TICK_W, default 16, width of tick_count.
REQ-002 SHALL have parameter MIN_PERIOD, default 2, smallest period programmed into the timer, in clocks.
REQ-003 clk  in  1  sole clock; all logic is rising-edge.
REQ-004 reset_n  in  1  reset; asynchronous, active-low.
REQ-005 cmd_start  in  1  1-cycle request: program period and start the timer in continuous mode.
REQ-006 cmd_period  in  32  requested period in clocks; sampled when cmd_start is accepted.
REQ-007 cmd_stop  in  1  1-cycle request: stop the timer and clear pending status.
REQ-008 cmd_snap  in  1  1-cycle request: snapshot the live counter and read it back.
REQ-009 busy  out  1  high in every state except IDLE and RUN.
REQ-010 running  out  1  high from WR_CTL completion until WR_STOP.
REQ-011 tick  out  1  1-cycle pulse per serviced timeout.
REQ-012 tick_count  out  TICK_W  serviced timeouts since the last accepted start; wraps.
REQ-013 snap_value  out  32  last snapshot value {high,low}.
REQ-014 snap_valid  out  1  1-cycle pulse when snap_value updates.
REQ-015 tmr_address  out  3  timer slave word address.
REQ-016 tmr_chipselect  out  1  timer slave select.
REQ-017 tmr_write_n  out  1  active-low write; 1 means read.
REQ-018 tmr_writedata  out  16  timer write data.
REQ-019 tmr_readdata  in  16  timer read data; registered, valid the cycle after address.
REQ-020 tmr_irq  in  1  timer interrupt; level, held until status is written.

Function
REQ-021 Timer map SHALL be 0 status (write clears timeout), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4 snap_l, 5 snap_h; zero wait states.
REQ-022 Each bus write SHALL last exactly one cycle (chipselect=1, write_n=0); when idle, chipselect=0, write_n=1, address=0, writedata=0.
REQ-023 States SHALL be IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR_ST, WR_STOP, CLR_STOP, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_CAP.
REQ-024 In IDLE and RUN, command priority SHALL be cmd_stop > cmd_start > cmd_snap; commands are ignored while busy=1.
REQ-025 In RUN, tmr_irq=1 SHALL take precedence over all commands.
REQ-026 On start accept: load = max(cmd_period, MIN_PERIOD) - 1; tick_count cleared; sequence WR_PL (addr 2, load[15:0]) -> WR_PH (addr 3, load[31:16]) -> WR_CTL (addr 1, data 0x0007) -> RUN.
REQ-027 cmd_start accepted in RUN SHALL reprogram the timer via the same sequence without an intermediate stop.
REQ-028 RUN with tmr_irq=1 -> CLR_ST: write addr 0, data 0; tick=1 in that cycle; tick_count+1 mod 2^TICK_W; -> RUN.
REQ-029 A timeout coinciding with the CLR_ST write SHALL be lost; no recovery.
REQ-030 cmd_stop -> WR_STOP (addr 1, data 0x0008) -> CLR_STOP (addr 0, data 0, no tick) -> IDLE; tick_count is held.
REQ-031 cmd_stop in IDLE SHALL still execute the stop sequence.
REQ-032 cmd_snap sequence SHALL be SNAP_WR (write addr 4, data 0) -> SNAP_RL (read addr 4) -> SNAP_RH (read addr 5, capture low) -> SNAP_CAP (capture high, snap_valid=1) -> the state that was active when cmd_snap was accepted.
REQ-033 A tmr_irq asserted during a snapshot SHALL be serviced on return to RUN, since irq is level-held.

Reset
REQ-034 While reset_n=0, the block SHALL be in IDLE with busy=0, running=0, tick=0, tick_count=0, snap_value=0, snap_valid=0, chipselect=0, write_n=1, address=0, writedata=0.
REQ-035 Reset asserted mid-sequence SHALL abort immediately; no partial write is completed after reset release.

Verification
REQ-036 Start with cmd_period=0x0001_86A0 -> writes (2,0x869F), (3,0x0001), (1,0x0007) on consecutive cycles; running=1.
REQ-037 With timer period 10 -> tick every 10 clocks; tick_count=5 after 5 timeouts; each irq is cleared by exactly one addr-0 write.
REQ-038 cmd_period=0 or 1 -> load=1 programmed: (2,0x0001), (3,0x0000).
REQ-039 cmd_stop and cmd_start in the same RUN cycle -> stop wins: (1,0x0008), (0,0x0000), IDLE; no tick; tick_count held.
REQ-040 cmd_snap in RUN with counter 0x0012_3456 at snap -> snap_value=0x0012_3456 with snap_valid 4 cycles after accept; back in RUN.
REQ-041 TICK_W=4 -> after 16 ticks tick_count=0; reset mid-WR_PH -> bus idle and IDLE state immediately.
